// File: rtl/uart_frame_loader.sv
// uart_frame_loader: syncs on a marker byte, packs byte pairs into 12-bit pixels
// and writes them to sequential async-SRAM addresses with timed write strobes.
module uart_frame_loader #(
    parameter int         FRAME_PIXELS = 307200,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         WE_CYCLES    = 3,
    parameter int         TIMEOUT      = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic [18:0] sram_addr,
    output logic [15:0] sram_wdata,
    output logic        sram_wdata_oe,
    output logic        sram_ce_n,
    output logic        sram_we_n,
    output logic        loading,
    output logic        frame_done,
    output logic        overrun,
    output logic        timeout_err
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, HI, LO, WRITE} state_t;

    state_t        state_q, state_d;
    logic [18:0]   addr_q, addr_d;
    logic [7:0]    rg_q, rg_d;
    logic [15:0]   wdata_q, wdata_d;
    logic          ce_n_q, ce_n_d, we_n_q, we_n_d, oe_q, oe_d;
    logic          loading_q, loading_d, done_q, done_d;
    logic          ovr_q, ovr_d, tmo_q, tmo_d;
    logic [7:0]    hold_q, hold_d;
    logic          hold_v_q, hold_v_d;
    logic [3:0]    wcnt_q, wcnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          byte_v;
    logic [7:0]    byte_b;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rg_d      = rg_q;
        wdata_d   = wdata_q;
        ce_n_d    = ce_n_q;
        we_n_d    = we_n_q;
        oe_d      = oe_q;
        loading_d = loading_q;
        done_d    = 1'b0;
        ovr_d     = ovr_q;
        tmo_d     = tmo_q;
        hold_d    = hold_q;
        hold_v_d  = hold_v_q;
        wcnt_d    = wcnt_q;
        tcnt_d    = tcnt_q;
        // A held byte is always older than a byte arriving this cycle
        byte_v    = hold_v_q | rx_valid;
        byte_b    = hold_v_q ? hold_q : rx_data;
        case (state_q)
            IDLE: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state_d   = HI;
                    addr_d    = '0;
                    ovr_d     = 1'b0;
                    tmo_d     = 1'b0;
                    loading_d = 1'b1;
                    tcnt_d    = '0;
                    hold_v_d  = 1'b0;
                end
            end
            HI, LO: begin
                if (hold_v_q) begin
                    hold_d   = rx_data;
                    hold_v_d = rx_valid;
                end
                if (byte_v) begin
                    if (state_q == HI) begin
                        rg_d    = byte_b;
                        state_d = LO;
                    end else begin
                        wdata_d = {4'h0, rg_q, byte_b[3:0]};
                        state_d = WRITE;
                        ce_n_d  = 1'b0;
                        we_n_d  = 1'b0;
                        oe_d    = 1'b1;
                        wcnt_d  = '0;
                    end
                end
                if (rx_valid) begin
                    tcnt_d = '0;
                end else if (!byte_v && tcnt_q == TW'(TIMEOUT - 1)) begin
                    tmo_d     = 1'b1;
                    loading_d = 1'b0;
                    state_d   = IDLE;
                    hold_v_d  = 1'b0;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            WRITE: begin
                tcnt_d = '0;
                if (rx_valid) begin
                    if (hold_v_q) begin
                        ovr_d = 1'b1;
                    end else begin
                        hold_d   = rx_data;
                        hold_v_d = 1'b1;
                    end
                end
                if (wcnt_q == 4'(WE_CYCLES)) begin
                    ce_n_d = 1'b1;
                    we_n_d = 1'b1;
                    oe_d   = 1'b0;
                    if (addr_q == 19'(FRAME_PIXELS - 1)) begin
                        done_d    = 1'b1;
                        loading_d = 1'b0;
                        state_d   = IDLE;
                        hold_v_d  = 1'b0;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = HI;
                    end
                end else begin
                    // Release WE one clock before CE to give the SRAM data hold time
                    wcnt_d = wcnt_q + 1'b1;
                    we_n_d = (wcnt_q == 4'(WE_CYCLES - 1));
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rg_q      <= '0;
            wdata_q   <= '0;
            ce_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            oe_q      <= 1'b0;
            loading_q <= 1'b0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
            tmo_q     <= 1'b0;
            hold_q    <= '0;
            hold_v_q  <= 1'b0;
            wcnt_q    <= '0;
            tcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rg_q      <= rg_d;
            wdata_q   <= wdata_d;
            ce_n_q    <= ce_n_d;
            we_n_q    <= we_n_d;
            oe_q      <= oe_d;
            loading_q <= loading_d;
            done_q    <= done_d;
            ovr_q     <= ovr_d;
            tmo_q     <= tmo_d;
            hold_q    <= hold_d;
            hold_v_q  <= hold_v_d;
            wcnt_q    <= wcnt_d;
            tcnt_q    <= tcnt_d;
        end
    end

    assign sram_addr     = addr_q;
    assign sram_wdata    = wdata_q;
    assign sram_wdata_oe = oe_q;
    assign sram_ce_n     = ce_n_q;
    assign sram_we_n     = we_n_q;
    assign loading       = loading_q;
    assign frame_done    = done_q;
    assign overrun       = ovr_q;
    assign timeout_err   = tmo_q;
endmodule

// File: tb/tb_uart_frame_loader.sv
// tb_uart_frame_loader: directed byte streams against a scoreboard of expected
// SRAM writes, plus a per-cycle monitor of the write-strobe protocol.
module tb_uart_frame_loader;
    localparam int FP = 4;
    localparam int WE = 3;
    localparam int TO = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [18:0] sram_addr;
    logic [15:0] sram_wdata;
    logic        sram_wdata_oe, sram_ce_n, sram_we_n;
    logic        loading, frame_done, overrun, timeout_err;

    uart_frame_loader #(
        .FRAME_PIXELS(FP), .SYNC_BYTE(8'hA5), .WE_CYCLES(WE), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_wdata_oe(sram_wdata_oe),
        .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n), .loading(loading),
        .frame_done(frame_done), .overrun(overrun), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          ce_low = 0;
    int          we_low = 0;
    logic [34:0] exp_q[$];
    logic [34:0] e;
    logic [18:0] cap_a;
    logic [15:0] cap_d;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick(1);
        rx_valid = 1'b0;
    endtask

    // Each completed CE-low window is one SRAM write, matched against the scoreboard
    always @(negedge clk) begin
        if (rst) begin
            ce_low = 0;
            we_low = 0;
        end else begin
            if (frame_done) done_cnt++;
            if (!sram_ce_n) begin
                if (ce_low == 0) begin
                    cap_a = sram_addr;
                    cap_d = sram_wdata;
                end else begin
                    chk("addr_stable", sram_addr, cap_a);
                    chk("data_stable", sram_wdata, cap_d);
                end
                chk("oe_during_write", sram_wdata_oe, 1);
                if (!sram_we_n) begin
                    chk("we_leads_window", we_low, ce_low);
                    we_low++;
                end
                ce_low++;
            end else begin
                chk("we_idle", sram_we_n, 1);
                chk("oe_idle", sram_wdata_oe, 0);
                if (ce_low != 0) begin
                    chk("ce_low_clocks", ce_low, WE + 1);
                    chk("we_low_clocks", we_low, WE);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: got addr %0h data %0h expected none", cap_a, cap_d);
                    end else begin
                        e = exp_q.pop_front();
                        chk("write_addr", cap_a, e[34:16]);
                        chk("write_data", cap_d, e[15:0]);
                    end
                    ce_low = 0;
                    we_low = 0;
                end
            end
        end
    end

    initial begin
        tick(2);
        chk("rst_ce_n", sram_ce_n, 1);
        chk("rst_we_n", sram_we_n, 1);
        chk("rst_oe", sram_wdata_oe, 0);
        chk("rst_addr", sram_addr, 0);
        chk("rst_wdata", sram_wdata, 0);
        chk("rst_flags", {loading, frame_done, overrun, timeout_err}, 0);
        rst = 1'b0;
        tick(1);

        // Garbage before sync is ignored
        send(8'h00); send(8'hFF); send(8'h12);
        tick(6);
        chk("pre_sync_loading", loading, 0);

        // Frame 1: plain pixel, pixel with early b0, pixel with overrun
        send(8'hA5);
        chk("sync_loading", loading, 1);
        send(8'h12);
        exp_q.push_back({19'd0, 16'h0124});
        send(8'h34);
        chk("write_we_low", sram_we_n, 0);
        send(8'h56);
        tick(4);
        exp_q.push_back({19'd1, 16'h0568});
        send(8'h78);
        tick(5);
        chk("mid_frame_loading", loading, 1);
        send(8'h9A);
        exp_q.push_back({19'd2, 16'h09AC});
        send(8'hBC);
        send(8'hDE);
        send(8'hF0);
        chk("overrun_set", overrun, 1);
        tick(3);
        exp_q.push_back({19'd3, 16'h0DE1});
        send(8'h21);
        tick(4);
        chk("frame_done_pulse", frame_done, 1);
        chk("done_loading", loading, 0);
        tick(1);
        chk("frame_done_single", frame_done, 0);
        chk("overrun_sticky", overrun, 1);
        send(8'h11); send(8'h22);
        tick(6);
        chk("done_count_1", done_cnt, 1);

        // Frame 2: sync value as pixel data, then timeout in LO
        send(8'hA5);
        chk("resync_overrun_clr", overrun, 0);
        chk("resync_addr", sram_addr, 0);
        send(8'hA5);
        exp_q.push_back({19'd0, 16'h0A5C});
        send(8'h5C);
        tick(5);
        send(8'h12);
        tick(TO - 1);
        chk("pre_timeout", {timeout_err, loading}, 2'b01);
        tick(1);
        chk("timeout", {timeout_err, loading}, 2'b10);

        // Frame 3: sync clears timeout and restarts at 0
        send(8'hA5);
        chk("post_timeout_sync", {timeout_err, loading}, 2'b01);
        chk("post_timeout_addr", sram_addr, 0);
        send(8'h0F);
        exp_q.push_back({19'd0, 16'h00FF});
        send(8'h0F);
        tick(5);

        // Reset in the middle of a write drops the strobes without a clock
        send(8'h33);
        send(8'h44);
        chk("pre_reset_we", sram_we_n, 0);
        #2 rst = 1'b1;
        #1;
        chk("async_we_n", sram_we_n, 1);
        chk("async_ce_n", sram_ce_n, 1);
        chk("async_oe", sram_wdata_oe, 0);
        tick(2);
        rst = 1'b0;
        tick(1);
        chk("post_reset", {loading, sram_addr, sram_wdata}, 0);
        send(8'h12); send(8'h34);
        tick(6);
        chk("post_reset_idle", loading, 0);
        chk("writes_outstanding", exp_q.size(), 0);
        chk("done_count_final", done_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
